// File: rtl/sccb_master_if.sv
// SCCB write-master request/bus bundle: config-sequencer handshake plus SIOC/SIOD drive lines.
// siod_in exists only when SCCB_ACK_CHECK_EN is defined.
`timescale 1ns/1ps

interface sccb_master_if;
  logic       start;
  logic [7:0] addr;
  logic [7:0] data;
  logic       ready;
  logic       sioc;
  logic       siod_out;
  logic       siod_oe;
  logic       ack_error;
`ifdef SCCB_ACK_CHECK_EN
  logic       siod_in;
`endif

  modport master (
`ifdef SCCB_ACK_CHECK_EN
    input  siod_in,
`endif
    input  start, addr, data,
    output ready, sioc, siod_out, siod_oe, ack_error
  );

  modport slave (
`ifdef SCCB_ACK_CHECK_EN
    output siod_in,
`endif
    output start, addr, data,
    input  ready, sioc, siod_out, siod_oe, ack_error
  );
endinterface

// File: rtl/sccb_master.sv
// SCCB 3-phase write master (ID, reg addr, reg data) for the OV7670 camera.
// Optional feature macro SCCB_ACK_CHECK_EN: sample SIOD on each released 9th bit, flag a missing ACK.
`timescale 1ns/1ps

module sccb_master #(
  parameter int         CLK_FREQ  = 25000000,
  parameter int         SCCB_FREQ = 100000,
  parameter logic [7:0] CAMERA_ID = 8'h42
) (
  input logic           clk,
  input logic           rst,
  sccb_master_if.master bus
);

  // QTR below 2 is not a legal configuration.
  localparam int QTR = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QTR - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    BITS,
    STOP,
    GAP
  } state_t;

  state_t        state;
  logic [QW-1:0] qcnt;
  logic [1:0]    quarter;
  logic [4:0]    bit_cnt;
  logic [26:0]   shift_reg;
  logic          ready_r;
  logic          sioc_r;
  logic          siod_r;
  logic          oe_r;
  logic          tick;

  assign tick = (qcnt == QLAST);

  // The 9th bit of each byte is the slave's ACK slot, where SIOD is released.
  function automatic logic is_ack_slot(input logic [4:0] idx);
    return (idx == 5'd8) || (idx == 5'd17) || (idx == 5'd26);
  endfunction

`ifdef SCCB_ACK_CHECK_EN
  logic ack_r;
  assign bus.ack_error = ack_r;
`else
  assign bus.ack_error = 1'b0;
`endif

  assign bus.ready    = ready_r;
  assign bus.sioc     = sioc_r;
  assign bus.siod_out = siod_r;
  assign bus.siod_oe  = oe_r;

  // Outputs are set on the quarter-tick that enters each quarter, so they hold for that whole quarter.
  // Leaving GAP lands in IDLE with ready still low; it rises one clock later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      qcnt      <= '0;
      quarter   <= '0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      ready_r   <= 1'b1;
      sioc_r    <= 1'b1;
      siod_r    <= 1'b1;
      oe_r      <= 1'b1;
`ifdef SCCB_ACK_CHECK_EN
      ack_r     <= 1'b0;
`endif
    end else if (state == IDLE) begin
      qcnt    <= '0;
      quarter <= '0;
      bit_cnt <= '0;
      if (!ready_r) begin
        ready_r <= 1'b1;
      end else if (bus.start) begin
        shift_reg <= {CAMERA_ID, 1'b1, bus.addr, 1'b1, bus.data, 1'b1};
        ready_r   <= 1'b0;
        state     <= START;
        sioc_r    <= 1'b1;
        siod_r    <= 1'b1;
        oe_r      <= 1'b1;
      end
    end else begin
      qcnt <= tick ? '0 : qcnt + QW'(1);
      if (tick) begin
        quarter <= quarter + 2'd1;
        case (state)
          START: begin
            case (quarter)
              2'd0: siod_r <= 1'b0;
              2'd1: sioc_r <= 1'b0;
              2'd3: begin
                state   <= BITS;
                bit_cnt <= 5'd0;
                siod_r  <= shift_reg[26];
                oe_r    <= 1'b1;
              end
              default: ;
            endcase
          end
          BITS: begin
            case (quarter)
              2'd1: sioc_r <= 1'b1;
`ifdef SCCB_ACK_CHECK_EN
              2'd2: begin
                if (is_ack_slot(bit_cnt) && bus.siod_in) ack_r <= 1'b1;
              end
`endif
              2'd3: begin
                sioc_r <= 1'b0;
                if (bit_cnt == 5'd26) begin
                  state  <= STOP;
                  siod_r <= 1'b0;
                  oe_r   <= 1'b1;
                end else begin
                  bit_cnt   <= bit_cnt + 5'd1;
                  shift_reg <= {shift_reg[25:0], 1'b0};
                  siod_r    <= shift_reg[25];
                  oe_r      <= !is_ack_slot(bit_cnt + 5'd1);
                end
              end
              default: ;
            endcase
          end
          STOP: begin
            case (quarter)
              2'd0: sioc_r <= 1'b1;
              2'd1: siod_r <= 1'b1;
              2'd3: state  <= GAP;
              default: ;
            endcase
          end
          GAP: begin
            if (quarter == 2'd3) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sccb_master.sv
// Self-checking bench for sccb_master: a bus monitor decodes SIOC/SIOD into frames compared to a byte-level model.
// Define SCCB_ACK_CHECK_EN to also exercise ACK sampling.
`timescale 1ns/1ps

module tb_sccb_master;

  localparam int         CLK_FREQ   = 400;
  localparam int         SCCB_FREQ  = 25;
  localparam int         QTR        = 4;
  localparam logic [7:0] CAM_ID     = 8'h42;
  localparam int         FRAME_CLKS = 120 * QTR + 1;
  localparam int         WAIT_MAX   = 4000;

  typedef struct {
    int          nbits;
    logic [26:0] bits;
    logic [26:0] oe;
    longint      start_cyc;
    longint      stop_cyc;
  } frame_t;

  logic   clk = 1'b0;
  logic   rst;
  int     pass_cnt = 0;
  int     check_cnt = 0;
  longint cyc = 0;

  sccb_master_if bus();

  sccb_master #(
    .CLK_FREQ (CLK_FREQ),
    .SCCB_FREQ(SCCB_FREQ),
    .CAMERA_ID(CAM_ID)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: start/stop are SIOD edges while SIOC is high; a bit is committed on SIOC fall.
  logic        prev_sioc = 1'b1;
  logic        prev_siod = 1'b1;
  logic        pending = 1'b0;
  logic        pend_val = 1'b0;
  logic        pend_oe = 1'b0;
  logic        in_frame = 1'b0;
  int          nbits = 0;
  logic [26:0] cur_bits = '0;
  logic [26:0] cur_oe = '0;
  longint      cur_start = 0;
  frame_t      frames[$];
  logic [2:0]  nack_mask = 3'b000;
  logic        ack_drive;

  always_comb begin
    ack_drive = 1'b0;
    if (!bus.siod_oe) begin
      case (nbits)
        8:       ack_drive = nack_mask[0];
        17:      ack_drive = nack_mask[1];
        26:      ack_drive = nack_mask[2];
        default: ack_drive = 1'b0;
      endcase
    end
  end

`ifdef SCCB_ACK_CHECK_EN
  assign bus.siod_in = ack_drive;
`endif

  always @(negedge clk) begin
    logic sc;
    logic sd;
    frame_t f;
    sc = bus.sioc;
    sd = bus.siod_oe ? bus.siod_out : ack_drive | ~nack_mask[0] | nack_mask[0];
`ifdef SCCB_ACK_CHECK_EN
    sd = bus.siod_oe ? bus.siod_out : ack_drive;
`endif
    if (prev_sioc && sc && prev_siod && !sd) begin
      in_frame  <= 1'b1;
      nbits     <= 0;
      pending   <= 1'b0;
      cur_start <= cyc;
    end else if (prev_sioc && sc && !prev_siod && sd) begin
      if (in_frame) begin
        f.nbits     = nbits;
        f.bits      = cur_bits;
        f.oe        = cur_oe;
        f.start_cyc = cur_start;
        f.stop_cyc  = cyc;
        frames.push_back(f);
      end
      in_frame <= 1'b0;
      pending  <= 1'b0;
    end else if (!prev_sioc && sc) begin
      pending  <= 1'b1;
      pend_val <= sd;
      pend_oe  <= bus.siod_oe;
    end else if (prev_sioc && !sc && pending) begin
      cur_bits <= {cur_bits[25:0], pend_val};
      cur_oe   <= {cur_oe[25:0], pend_oe};
      nbits    <= nbits + 1;
      pending  <= 1'b0;
    end
    prev_sioc <= sc;
    prev_siod <= sd;
  end

  // Reference: three bytes MSB first, each followed by a released ACK slot.
  function automatic void model_frame(input logic [7:0] a, input logic [7:0] d,
                                      output logic [26:0] v, output logic [26:0] m);
    logic [7:0] by [3];
    int pos;
    by[0] = CAM_ID;
    by[1] = a;
    by[2] = d;
    pos = 26;
    v = '0;
    m = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 7; j >= 0; j--) begin
        v[pos] = by[i][j];
        m[pos] = 1'b1;
        pos--;
      end
      m[pos] = 1'b0;
      pos--;
    end
  endfunction

  task automatic wait_ready(output int n);
    n = 0;
    while (!bus.ready && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d,
                          output logic rdy_after, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr  = a;
    bus.data  = d;
    @(negedge clk);
    bus.start = 1'b0;
    rdy_after = bus.ready;
    wait_ready(lat);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.addr  = '0;
    bus.data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check_cnt++;
      if ({bus.ready, bus.sioc, bus.siod_out, bus.siod_oe, bus.ack_error} !== 5'b11110)
        $display("[TB] FAIL reset_idle cyc%0d: got %b want 11110", i,
                 {bus.ready, bus.sioc, bus.siod_out, bus.siod_oe, bus.ack_error});
      else pass_cnt++;
    end
    frames.delete();
  endtask

  task automatic test_single_write();
    logic rdy;
    int lat;
    logic [26:0] v, m;
    frame_t f;
    frames.delete();
    model_frame(8'h12, 8'h80, v, m);
    do_write(8'h12, 8'h80, rdy, lat);
    check_cnt++;
    if (rdy !== 1'b0) $display("[TB] FAIL single_ready_low: got %b want 0", rdy);
    else pass_cnt++;
    check_cnt++;
    if (lat !== FRAME_CLKS) $display("[TB] FAIL single_latency: got %0d want %0d", lat, FRAME_CLKS);
    else pass_cnt++;
    check_cnt++;
    if (frames.size() !== 1) $display("[TB] FAIL single_frames: got %0d want 1", frames.size());
    else begin
      pass_cnt++;
      f = frames.pop_front();
      check_cnt++;
      if (f.nbits !== 27) $display("[TB] FAIL single_nbits: got %0d want 27", f.nbits);
      else pass_cnt++;
      check_cnt++;
      if (f.oe !== m) $display("[TB] FAIL single_oe: got %h want %h", f.oe, m);
      else pass_cnt++;
      check_cnt++;
      if ((f.bits & m) !== v) $display("[TB] FAIL single_bits: got %h want %h", f.bits & m, v);
      else pass_cnt++;
    end
  endtask

  task automatic test_busy_ignored();
    int n;
    logic [26:0] v, m;
    frame_t f;
    frames.delete();
    model_frame(8'h12, 8'h80, v, m);
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr  = 8'h12;
    bus.data  = 8'h80;
    @(negedge clk);
    bus.start = 1'b0;
    repeat ($urandom_range(20, 300)) @(negedge clk);
    bus.addr  = 8'hFF;
    bus.data  = 8'($urandom);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check_cnt++;
    if (bus.ready !== 1'b0) $display("[TB] FAIL busy_still_busy: got %b want 0", bus.ready);
    else pass_cnt++;
    wait_ready(n);
    repeat (40) @(negedge clk);
    check_cnt++;
    if (bus.ready !== 1'b1) $display("[TB] FAIL busy_no_second: ready got %b want 1", bus.ready);
    else pass_cnt++;
    check_cnt++;
    if (frames.size() !== 1) $display("[TB] FAIL busy_frames: got %0d want 1", frames.size());
    else begin
      pass_cnt++;
      f = frames.pop_front();
      check_cnt++;
      if ((f.bits & m) !== v || f.oe !== m || f.nbits !== 27)
        $display("[TB] FAIL busy_content: got %h/%h/%0d want %h/%h/27", f.bits & m, f.oe, f.nbits, v, m);
      else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] a1, d1;
    logic [26:0] v1, m1, v2, m2;
    frame_t f1, f2;
    frames.delete();
    a1 = 8'($urandom);
    d1 = 8'($urandom);
    model_frame(a1, d1, v1, m1);
    model_frame(8'h3A, 8'h04, v2, m2);
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr  = a1;
    bus.data  = d1;
    @(negedge clk);
    bus.addr = 8'h3A;
    bus.data = 8'h04;
    wait_ready(n);
    check_cnt++;
    if (n !== FRAME_CLKS) $display("[TB] FAIL b2b_latency1: got %0d want %0d", n, FRAME_CLKS);
    else pass_cnt++;
    @(negedge clk);
    bus.start = 1'b0;
    check_cnt++;
    if (bus.ready !== 1'b0) $display("[TB] FAIL b2b_accept_on_rise: ready got %b want 0", bus.ready);
    else pass_cnt++;
    wait_ready(n);
    check_cnt++;
    if (n !== FRAME_CLKS) $display("[TB] FAIL b2b_latency2: got %0d want %0d", n, FRAME_CLKS);
    else pass_cnt++;
    check_cnt++;
    if (frames.size() !== 2) $display("[TB] FAIL b2b_frames: got %0d want 2", frames.size());
    else begin
      pass_cnt++;
      f1 = frames.pop_front();
      f2 = frames.pop_front();
      check_cnt++;
      if ((f1.bits & m1) !== v1 || f1.oe !== m1 || f1.nbits !== 27)
        $display("[TB] FAIL b2b_frame1: got %h/%h/%0d want %h/%h/27", f1.bits & m1, f1.oe, f1.nbits, v1, m1);
      else pass_cnt++;
      check_cnt++;
      if ((f2.bits & m2) !== v2 || f2.oe !== m2 || f2.nbits !== 27)
        $display("[TB] FAIL b2b_frame2: got %h/%h/%0d want %h/%h/27", f2.bits & m2, f2.oe, f2.nbits, v2, m2);
      else pass_cnt++;
      check_cnt++;
      if (f2.start_cyc - f1.stop_cyc < 6 * QTR)
        $display("[TB] FAIL b2b_gap: got %0d clks want >= %0d", f2.start_cyc - f1.stop_cyc, 6 * QTR);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic rdy;
    logic [7:0] a, d;
    logic [26:0] v, m;
    frame_t f;
    @(negedge clk);
    bus.start = 1'b1;
    bus.addr  = 8'($urandom);
    bus.data  = 8'($urandom);
    @(negedge clk);
    bus.start = 1'b0;
    n = 0;
    while (!(in_frame && nbits >= 10) && n < WAIT_MAX) begin
      @(negedge clk);
      n++;
    end
    check_cnt++;
    if (n >= WAIT_MAX) $display("[TB] FAIL rstmid_reach_bit10: got timeout want bit 10");
    else pass_cnt++;
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    check_cnt++;
    if ({bus.sioc, bus.siod_out, bus.siod_oe, bus.ready} !== 4'b1111)
      $display("[TB] FAIL rstmid_lines: got %b want 1111", {bus.sioc, bus.siod_out, bus.siod_oe, bus.ready});
    else pass_cnt++;
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check_cnt++;
    if (bus.ready !== 1'b1) $display("[TB] FAIL rstmid_rst_dominates: ready got %b want 1", bus.ready);
    else pass_cnt++;
    frames.delete();
    a = 8'($urandom);
    d = 8'($urandom);
    model_frame(a, d, v, m);
    do_write(a, d, rdy, n);
    check_cnt++;
    if (n !== FRAME_CLKS) $display("[TB] FAIL rstmid_latency: got %0d want %0d", n, FRAME_CLKS);
    else pass_cnt++;
    check_cnt++;
    if (frames.size() !== 1) $display("[TB] FAIL rstmid_frames: got %0d want 1", frames.size());
    else begin
      pass_cnt++;
      f = frames.pop_front();
      check_cnt++;
      if ((f.bits & m) !== v || f.oe !== m || f.nbits !== 27)
        $display("[TB] FAIL rstmid_content: got %h/%h/%0d want %h/%h/27", f.bits & m, f.oe, f.nbits, v, m);
      else pass_cnt++;
    end
  endtask

  task automatic test_random_writes();
    int n;
    logic rdy;
    logic [7:0] a, d;
    logic [26:0] v, m;
    frame_t f;
    for (int k = 0; k < 6; k++) begin
      frames.delete();
      repeat ($urandom_range(0, 10)) @(negedge clk);
      a = 8'($urandom);
      d = 8'($urandom);
      model_frame(a, d, v, m);
      do_write(a, d, rdy, n);
      check_cnt++;
      if (n !== FRAME_CLKS || rdy !== 1'b0)
        $display("[TB] FAIL rand%0d_timing: got %0d/%b want %0d/0", k, n, rdy, FRAME_CLKS);
      else pass_cnt++;
      check_cnt++;
      if (frames.size() !== 1) $display("[TB] FAIL rand%0d_frames: got %0d want 1", k, frames.size());
      else begin
        pass_cnt++;
        f = frames.pop_front();
        check_cnt++;
        if ((f.bits & m) !== v || f.oe !== m || f.nbits !== 27)
          $display("[TB] FAIL rand%0d_content: got %h/%h/%0d want %h/%h/27", k, f.bits & m, f.oe, f.nbits, v, m);
        else pass_cnt++;
      end
      check_cnt++;
      if (bus.ack_error !== 1'b0) $display("[TB] FAIL rand%0d_ack_error: got %b want 0", k, bus.ack_error);
      else pass_cnt++;
    end
  endtask

`ifdef SCCB_ACK_CHECK_EN
  task automatic test_ack_check();
    int n;
    logic rdy;
    nack_mask = 3'b010;
    do_write(8'($urandom), 8'($urandom), rdy, n);
    check_cnt++;
    if (bus.ack_error !== 1'b1) $display("[TB] FAIL ack_nack2: got %b want 1", bus.ack_error);
    else pass_cnt++;
    repeat (10) @(negedge clk);
    nack_mask = 3'b000;
    do_write(8'($urandom), 8'($urandom), rdy, n);
    check_cnt++;
    if (bus.ack_error !== 1'b1) $display("[TB] FAIL ack_sticky: got %b want 1", bus.ack_error);
    else pass_cnt++;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_cnt++;
    if (bus.ack_error !== 1'b0) $display("[TB] FAIL ack_cleared: got %b want 0", bus.ack_error);
    else pass_cnt++;
    do_write(8'($urandom), 8'($urandom), rdy, n);
    check_cnt++;
    if (bus.ack_error !== 1'b0) $display("[TB] FAIL ack_all_acked: got %b want 0", bus.ack_error);
    else pass_cnt++;
    nack_mask = 3'b100;
    do_write(8'($urandom), 8'($urandom), rdy, n);
    nack_mask = 3'b000;
    check_cnt++;
    if (bus.ack_error !== 1'b1) $display("[TB] FAIL ack_nack3: got %b want 1", bus.ack_error);
    else pass_cnt++;
  endtask
`endif

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.addr  = '0;
    bus.data  = '0;
    test_reset();
    test_single_write();
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid();
    test_random_writes();
`ifdef SCCB_ACK_CHECK_EN
    test_ack_check();
`endif
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
